// File: rtl/tl_bus_arbiter_pkg.sv
// Shared definitions for the two-port TileLink-UL A/D arbiter.
package tl_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARB    = 2'd1,
    ST_WAIT_D = 2'd2
  } arb_state_e;

  localparam logic [3:0] TL_OP_GET         = 4'd4;
  localparam logic [3:0] TL_OP_PUT_FULL    = 4'd0;
  localparam logic [3:0] TL_OP_PUT_PARTIAL = 4'd1;

  localparam logic SRC_ICACHE = 1'b0;
  localparam logic SRC_DCACHE = 1'b1;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/tl_bus_arbiter_if.sv
// A/D channel handshake bundle between the two requesters, the downstream bus and the arbiter.
interface tl_bus_arbiter_if;
  logic io_in_0_valid;
  logic io_in_1_valid;
  logic io_out_ready;
  logic io_choseOH_0;
  logic io_choseOH_1;
  logic io_d_valid;
  logic io_d_bits_source;
  logic io_d_ready;
  logic io_d_0_valid;
  logic io_d_1_valid;
  logic io_d_0_ready;
  logic io_d_1_ready;
  logic io_busy;
  logic io_src_err;
  logic io_timeout;

  // slave = the arbiter itself; master = the surrounding requesters/bus
  modport slave (
    input  io_in_0_valid, io_in_1_valid, io_out_ready,
    input  io_d_valid, io_d_bits_source, io_d_0_ready, io_d_1_ready,
    output io_choseOH_0, io_choseOH_1, io_d_ready, io_d_0_valid, io_d_1_valid,
    output io_busy, io_src_err, io_timeout
  );

  modport master (
    output io_in_0_valid, io_in_1_valid, io_out_ready,
    output io_d_valid, io_d_bits_source, io_d_0_ready, io_d_1_ready,
    input  io_choseOH_0, io_choseOH_1, io_d_ready, io_d_0_valid, io_d_1_valid,
    input  io_busy, io_src_err, io_timeout
  );
endinterface

// File: rtl/tl_bus_arbiter_rr_pick.sv
// Combinational 2-way round-robin picker; ptr selects the winner only on contention.
module tl_rr_pick (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       any
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

  assign any = |valid;

endmodule

// File: rtl/tl_bus_arbiter.sv
// Two-requester A/D sequencer: one transaction in flight, registered mux select, D routing,
// source-mismatch flag and WAIT_D watchdog.
//
//  state     | meaning
//  ST_IDLE   | no owner; arbitrate pending requests
//  ST_ARB    | owner's A beat offered on the bus (choseOH = onehot(owner))
//  ST_WAIT_D | A beat accepted; waiting for the D response, watchdog running
module tl_bus_arbiter
  import tl_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input logic           clock,
  input logic           reset,
  tl_bus_arbiter_if.slave bus
);

  localparam logic             WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] WDOG_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e       state_q, state_d;
  logic             owner_q, owner_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic [1:0]       chose_q, chose_d;

  logic [1:0] pick_grant;
  logic       pick_any;
  logic       owner_valid, owner_d_ready, a_fire, d_fire;
  logic       d_ready, d_0_valid, d_1_valid, src_err, timeout;

  tl_rr_pick u_pick (
    .valid ({bus.io_in_1_valid, bus.io_in_0_valid}),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .any   (pick_any)
  );

  assign owner_valid   = owner_q ? bus.io_in_1_valid : bus.io_in_0_valid;
  assign owner_d_ready = owner_q ? bus.io_d_1_ready  : bus.io_d_0_ready;
  assign a_fire        = owner_valid & bus.io_out_ready;
  assign d_fire        = bus.io_d_valid & owner_d_ready;

  // Watchdog is a down-counter loaded at A fire; terminal count 0 is the last allowed cycle.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    wdog_d    = wdog_q;
    d_ready   = 1'b0;
    d_0_valid = 1'b0;
    d_1_valid = 1'b0;
    src_err   = 1'b0;
    timeout   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_ARB;
          owner_d = pick_grant[1];
        end
      end
      ST_ARB: begin
        if (a_fire) begin
          state_d  = ST_WAIT_D;
          rr_ptr_d = ~owner_q;
          wdog_d   = WDOG_LOAD;
        end
      end
      ST_WAIT_D: begin
        d_ready   = owner_d_ready;
        d_0_valid = bus.io_d_valid & ~owner_q;
        d_1_valid = bus.io_d_valid &  owner_q;
        if (d_fire) begin
          state_d = ST_IDLE;
          src_err = (bus.io_d_bits_source != owner_q);
        end else if (WDOG_EN && (wdog_q == '0)) begin
          state_d = ST_IDLE;
          timeout = 1'b1;
        end else begin
          wdog_d = wdog_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    chose_d = (state_d == ST_ARB) ? onehot2(owner_d) : 2'b00;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
      wdog_q   <= '0;
      chose_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      wdog_q   <= wdog_d;
      chose_q  <= chose_d;
    end
  end

  assign bus.io_choseOH_0 = chose_q[0];
  assign bus.io_choseOH_1 = chose_q[1];
  assign bus.io_d_ready   = d_ready;
  assign bus.io_d_0_valid = d_0_valid;
  assign bus.io_d_1_valid = d_1_valid;
  assign bus.io_busy      = (state_q != ST_IDLE);
  assign bus.io_src_err   = src_err;
  assign bus.io_timeout   = timeout;

endmodule

// File: tb/tb_tl_bus_arbiter.sv
// Directed bench for tl_bus_arbiter: per-cycle vector table plus hand-written corner sequences.
module tb_tl_bus_arbiter;
  import tl_bus_arbiter_pkg::*;

  // in  = {in0_v, in1_v, out_ready, d_valid, d_src, d0_ready, d1_ready}
  // exp = {choseOH_1, choseOH_0, d_ready, d_1_valid, d_0_valid, busy, src_err, timeout}
  typedef struct {
    string      name;
    logic [6:0] in;
    logic [7:0] exp;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  vec_t vq[$];

  tl_bus_arbiter_if bus ();

  tl_bus_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] outs();
    return {bus.io_choseOH_1, bus.io_choseOH_0, bus.io_d_ready, bus.io_d_1_valid,
            bus.io_d_0_valid, bus.io_busy, bus.io_src_err, bus.io_timeout};
  endfunction

  task automatic drive(input logic [6:0] in);
    {bus.io_in_0_valid, bus.io_in_1_valid, bus.io_out_ready, bus.io_d_valid,
     bus.io_d_bits_source, bus.io_d_0_ready, bus.io_d_1_ready} = in;
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = outs();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Called at a negedge: drive, let comb logic settle, check, advance to the next negedge.
  task automatic cyc(input string name, input logic [6:0] in, input logic [7:0] exp);
    drive(in);
    #1;
    check(name, exp);
    @(negedge clock);
  endtask

  task automatic add(input string name, input logic [6:0] in, input logic [7:0] exp);
    vec_t v;
    v.name = name;
    v.in   = in;
    v.exp  = exp;
    vq.push_back(v);
  endtask

  initial begin
    add("t1_idle_req0",   7'b1000000, 8'b00000000);
    add("t1_arb_chose0",  7'b1010000, 8'b01000100);
    add("t1_waitd_d0",    7'b0001010, 8'b00101100);
    add("t1_idle",        7'b0000000, 8'b00000000);
    add("rr1_idle_both",  7'b1100000, 8'b00000000);
    add("rr1_arb_chose1", 7'b1110000, 8'b10000100);
    add("t5_src_err",     7'b1101001, 8'b00110110);
    add("t2_idle_a",      7'b1100000, 8'b00000000);
    add("t2_grant0",      7'b1110000, 8'b01000100);
    add("t2_d0",          7'b1101011, 8'b00101100);
    add("t2_idle_b",      7'b1100000, 8'b00000000);
    add("t2_grant1",      7'b1110000, 8'b10000100);
    add("t2_d1",          7'b1101101, 8'b00110100);
    add("idle_req0",      7'b1000000, 8'b00000000);
    add("arb_hold_a",     7'b1000000, 8'b01000100);
    add("arb_hold_b",     7'b1000000, 8'b01000100);
    add("arb_fire",       7'b1010000, 8'b01000100);
    add("d_stall",        7'b0001001, 8'b00001100);
    add("d_release",      7'b0001010, 8'b00101100);
    add("stray_d_idle",   7'b0001010, 8'b00000000);

    drive(7'b1001010);
    @(negedge clock);
    #1;
    check("reset_outputs", 8'b00000000);
    @(negedge clock);
    reset = 1'b1;

    foreach (vq[i]) cyc(vq[i].name, vq[i].in, vq[i].exp);

    // ARB stall for 5 cycles with out_ready low, owner 1 (rr_ptr = 1 here)
    cyc("t3_idle", 7'b0100000, 8'b00000000);
    for (int k = 0; k < 5; k++) cyc("t3_hold", 7'b0100000, 8'b10000100);
    cyc("t3_fire", 7'b0110000, 8'b10000100);
    cyc("t3_waitd", 7'b0000000, 8'b00000100);
    cyc("t3_d1", 7'b0001101, 8'b00110100);
    cyc("t3_idle_after", 7'b0000000, 8'b00000000);

    // Watchdog expiry after 8 WAIT_D cycles
    cyc("t4_idle", 7'b1010000, 8'b00000000);
    cyc("t4_arb", 7'b1010000, 8'b01000100);
    for (int k = 1; k <= 7; k++) cyc("t4_wait", 7'b0000000, 8'b00000100);
    cyc("t4_timeout", 7'b0000000, 8'b00000101);
    cyc("t4_idle_after", 7'b0000000, 8'b00000000);

    // D fire on the expiry cycle wins over the watchdog
    cyc("td_idle", 7'b0110000, 8'b00000000);
    cyc("td_arb", 7'b0110000, 8'b10000100);
    for (int k = 1; k <= 7; k++) cyc("td_wait", 7'b0000000, 8'b00000100);
    cyc("td_d_wins", 7'b0001101, 8'b00110100);
    cyc("td_idle_after", 7'b0000000, 8'b00000000);

    // Reset asserted while in ARB clears the registered select without a clock edge
    cyc("r_idle", 7'b0100000, 8'b00000000);
    drive(7'b0100000);
    #1;
    check("r_arb", 8'b10000100);
    #2;
    reset = 1'b0;
    #1;
    check("r_reset_in_arb", 8'b00000000);
    @(negedge clock);
    reset = 1'b1;

    // Reset in WAIT_D with rr_ptr = 1; first grant afterwards must be requester 0
    cyc("t6_idle", 7'b1000000, 8'b00000000);
    cyc("t6_arb", 7'b1010000, 8'b01000100);
    drive(7'b0000000);
    #1;
    check("t6_waitd", 8'b00000100);
    #2;
    reset = 1'b0;
    #1;
    check("t6_reset_in_waitd", 8'b00000000);
    @(negedge clock);
    reset = 1'b1;
    cyc("t6_idle_both", 7'b1100000, 8'b00000000);
    cyc("t6_first_grant0", 7'b1100000, 8'b01000100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
